// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Purpose  : Shared definitions for the multicycle MIPS-style controller:
//            FSM state enumeration, opcode/func constants, datapath select
//            encodings and the bundled control-word struct.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JR     = 4'd12
    } state_t;

    // Opcode field (instr[31:26])
    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_ANDI  = 6'h0C;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    // Func field (instr[5:0]) values with special control treatment
    localparam logic [5:0] C_FN_SLL   = 6'h00;
    localparam logic [5:0] C_FN_JR    = 6'h08;

    // alu_op
    localparam logic [1:0] C_ALU_ADD   = 2'b00;
    localparam logic [1:0] C_ALU_SUB   = 2'b01;
    localparam logic [1:0] C_ALU_FUNCT = 2'b10;
    localparam logic [1:0] C_ALU_AND   = 2'b11;

    // alu_src_a
    localparam logic [1:0] C_SRCA_PC    = 2'd0;
    localparam logic [1:0] C_SRCA_RS    = 2'd1;
    localparam logic [1:0] C_SRCA_SHAMT = 2'd2;

    // alu_src_b
    localparam logic [1:0] C_SRCB_RT     = 2'd0;
    localparam logic [1:0] C_SRCB_FOUR   = 2'd1;
    localparam logic [1:0] C_SRCB_IMM    = 2'd2;
    localparam logic [1:0] C_SRCB_IMMSH2 = 2'd3;

    // pc_source
    localparam logic [1:0] C_PCSRC_ALU    = 2'd0;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] C_PCSRC_RS     = 2'd3;

    // reg_dst
    localparam logic [1:0] C_DST_RT = 2'd0;
    localparam logic [1:0] C_DST_RD = 2'd1;
    localparam logic [1:0] C_DST_RA = 2'd2;

    // mem_to_reg
    localparam logic [1:0] C_WB_ALU = 2'd0;
    localparam logic [1:0] C_WB_MEM = 2'd1;
    localparam logic [1:0] C_WB_PC  = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == C_OP_RTYPE) || (op == C_OP_JAL)  || (op == C_OP_BEQ) ||
               (op == C_OP_ADDI)  || (op == C_OP_ANDI) || (op == C_OP_LW)  ||
               (op == C_OP_SW);
    endfunction

endpackage : multicycle_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Purely combinational state-to-control-word table.
// Ports    : state     - current FSM state
//            opcode    - instr[31:26]
//            func      - instr[5:0]
//            mem_ready - effective memory-ready (already forced to 1 when
//                        the handshake is disabled)
//            ctrl      - full control word (strobes + selects + illegal)
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                // IR and PC only capture once the instruction word is valid
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_a = C_SRCA_PC;
                ctrl.alu_src_b = C_SRCB_FOUR;
                ctrl.alu_op    = C_ALU_ADD;
                ctrl.pc_source = C_PCSRC_ALU;
            end
            S_DECODE: begin
                // Branch target is precomputed speculatively into ALUOut
                ctrl.alu_src_a = C_SRCA_PC;
                ctrl.alu_src_b = C_SRCB_IMMSH2;
                ctrl.alu_op    = C_ALU_ADD;
                ctrl.illegal   = !op_is_legal(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = C_SRCA_RS;
                ctrl.alu_src_b = C_SRCB_IMM;
                ctrl.alu_op    = C_ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = C_DST_RT;
                ctrl.mem_to_reg = C_WB_MEM;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_RTEXEC: begin
                ctrl.alu_op    = C_ALU_FUNCT;
                ctrl.alu_src_b = C_SRCB_RT;
                ctrl.alu_src_a = (func == C_FN_SLL) ? C_SRCA_SHAMT : C_SRCA_RS;
            end
            S_RTWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = C_DST_RD;
                ctrl.mem_to_reg = C_WB_ALU;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = C_SRCA_RS;
                ctrl.alu_src_b = C_SRCB_IMM;
                ctrl.alu_op    = (opcode == C_OP_ANDI) ? C_ALU_AND : C_ALU_ADD;
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = C_DST_RT;
                ctrl.mem_to_reg = C_WB_ALU;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = C_SRCA_RS;
                ctrl.alu_src_b     = C_SRCB_RT;
                ctrl.alu_op        = C_ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = C_PCSRC_ALUOUT;
            end
            S_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = C_DST_RA;
                ctrl.mem_to_reg = C_WB_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = C_PCSRC_JUMP;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = C_PCSRC_RS;
            end
            default: ctrl = '0;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle controller FSM with retired-instruction counter.
// Ports    : clock, reset_n (async, active-low)
//            opcode, func   - instruction fields from the IR
//            zero           - ALU zero flag (consumed by datapath PC logic)
//            mem_ready      - unified memory completion
//            pc_write .. reg_write - datapath strobes
//            reg_dst .. pc_source  - datapath mux selects
//            illegal        - one-cycle pulse on undecodable opcode
//            retired        - completed-instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal,
    output logic [15:0] retired
);

    state_t      r_state;
    state_t      w_next;
    logic        w_ready;
    logic        w_retire;
    logic [15:0] r_retired;
    ctrl_t       w_ctrl;
    ctrl_t       w_ctrl_gated;
    // zero gates pc_write_cond inside the datapath, not here
    logic        w_unused_zero;

    assign w_unused_zero = zero;
    assign w_ready       = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    C_OP_LW, C_OP_SW:     w_next = S_MEMADR;
                    C_OP_RTYPE:           w_next = (func == C_FN_JR) ? S_JR : S_RTEXEC;
                    C_OP_ADDI, C_OP_ANDI: w_next = S_IEXEC;
                    C_OP_BEQ:             w_next = S_BRANCH;
                    C_OP_JAL:             w_next = S_JAL;
                    default:              w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == C_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (w_ready) w_next = S_MEMWB;
            S_MEMWR:  if (w_ready) w_next = S_FETCH;
            S_RTEXEC: w_next = S_RTWB;
            S_IEXEC:  w_next = S_IWB;
            S_MEMWB, S_RTWB, S_IWB, S_BRANCH, S_JAL, S_JR: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // An instruction retires on any return to FETCH except the illegal-opcode
    // bounce out of DECODE (and FETCH's own self-loop).
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                      (r_state != S_DECODE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= 16'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    // Output logic
    ctrl_decode u_ctrl_decode (
        .state     (r_state),
        .opcode    (opcode),
        .func      (func),
        .mem_ready (w_ready),
        .ctrl      (w_ctrl)
    );

    // FETCH drives mem_read, so the word is forced quiet while reset is held
    always_comb begin
        w_ctrl_gated = reset_n ? w_ctrl : '0;
    end

    assign pc_write      = w_ctrl_gated.pc_write;
    assign pc_write_cond = w_ctrl_gated.pc_write_cond;
    assign iord          = w_ctrl_gated.iord;
    assign mem_read      = w_ctrl_gated.mem_read;
    assign mem_write     = w_ctrl_gated.mem_write;
    assign ir_write      = w_ctrl_gated.ir_write;
    assign reg_write     = w_ctrl_gated.reg_write;
    assign illegal       = w_ctrl_gated.illegal;
    assign reg_dst       = w_ctrl_gated.reg_dst;
    assign mem_to_reg    = w_ctrl_gated.mem_to_reg;
    assign alu_src_a     = w_ctrl_gated.alu_src_a;
    assign alu_src_b     = w_ctrl_gated.alu_src_b;
    assign alu_op        = w_ctrl_gated.alu_op;
    assign pc_source     = w_ctrl_gated.pc_source;
    assign retired       = r_retired;

endmodule : multicycle_ctrl
`default_nettype wire
